// File: rtl/boot_rom_pkg.sv
// Shared types and helpers for the multi-channel boot ROM.
package boot_rom_pkg;
  localparam int MaxCh = 8;
  localparam int ChW   = 3;
  localparam int MaxPw = 129;

  // s1 stage: grant information captured at accept time
  typedef struct packed {
    logic           valid;
    logic [ChW-1:0] ch;
    logic           err_pre;
  } rom_req_t;

  // Odd-parity detect; callers zero-extend their word to MaxPw bits.
  function automatic logic par_odd(input logic [MaxPw-1:0] w);
    return ^w;
  endfunction
endpackage

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at the pointer and wraps.
module rom_rr_arbiter
  import boot_rom_pkg::*;
#(
  parameter int NumCh = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NumCh-1:0] req,
  input  logic             advance,
  output logic [NumCh-1:0] gnt,
  output logic [ChW-1:0]   gnt_idx
);
  logic [ChW-1:0] ptr_q, ptr_d;

  // Two passes: lowest requester overall, then lowest at/above the pointer overrides it.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    ptr_d   = ptr_q;
    for (int c = NumCh - 1; c >= 0; c--) begin
      if (req[c]) begin
        gnt     = '0;
        gnt[c]  = 1'b1;
        gnt_idx = ChW'(c);
        ptr_d   = (c == NumCh - 1) ? '0 : ChW'(c + 1);
      end
    end
    for (int c = NumCh - 1; c >= 0; c--) begin
      if (req[c] && (ChW'(c) >= ptr_q)) begin
        gnt     = '0;
        gnt[c]  = 1'b1;
        gnt_idx = ChW'(c);
        ptr_d   = (c == NumCh - 1) ? '0 : ChW'(c + 1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        ptr_q <= '0;
    else if (advance) ptr_q <= ptr_d;
  end
endmodule

// File: rtl/boot_rom_mc.sv
// Multi-channel boot ROM: rr-arbitrated single-port array, optional output
// register, per-word even parity and a sticky post-boot lock.
module boot_rom_mc
  import boot_rom_pkg::*;
#(
  parameter int Width    = 32,
  parameter int Depth    = 4096,
  parameter int NumCh    = 2,
  parameter int OutReg   = 1,
  parameter int ParityEn = 1,
  parameter int Aw       = $clog2(Depth)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumCh-1:0]       req_i,
  input  logic [NumCh*Aw-1:0]    addr_i,
  output logic [NumCh-1:0]       gnt_o,
  output logic [NumCh-1:0]       rvalid_o,
  output logic [NumCh*Width-1:0] rdata_o,
  output logic [NumCh-1:0]       err_o,
  input  logic                   lock_i,
  output logic                   locked_o
);
  localparam int Ww = Width + ((ParityEn != 0) ? 1 : 0);

  typedef struct packed {
    logic             valid;
    logic [ChW-1:0]   ch;
    logic             err;
    logic [Width-1:0] data;
  } rom_rsp_t;

  logic [NumCh-1:0][Aw-1:0] addr_a;
  logic [ChW-1:0]           gnt_idx;
  logic                     accept;
  logic [Aw-1:0]            sel_addr;
  logic                     range_err;
  logic                     cs;
  rom_req_t                 s1_q;
  logic [Ww-1:0]            mem [Depth];
  logic [Ww-1:0]            rd_q;
  logic                     par_err;
  rom_rsp_t                 rsp1, rsp_out;

  assign addr_a = addr_i;

  rom_rr_arbiter #(.NumCh(NumCh)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req_i),
    .advance (accept),
    .gnt     (gnt_o),
    .gnt_idx (gnt_idx)
  );

  assign accept = |gnt_o;

  always_comb begin
    sel_addr = '0;
    for (int c = 0; c < NumCh; c++)
      if (gnt_o[c]) sel_addr = addr_a[c];
  end

  assign range_err = ({1'b0, sel_addr} >= (Aw+1)'(Depth));
  // Range and lock errors are resolved at grant, so the array is never touched for them.
  assign cs        = accept & ~(range_err | locked_o);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= '0;
      locked_o <= 1'b0;
    end else begin
      s1_q     <= '{valid: accept, ch: gnt_idx, err_pre: range_err | locked_o};
      locked_o <= locked_o | lock_i;
    end
  end

`ifdef SECSOC_FPGA
  secsoc_rom_macro #(.Width(Ww), .Depth(Depth)) u_rom (
    .clk_i   (clk_i),
    .cs_i    (cs),
    .addr_i  (sel_addr),
    .rdata_o (rd_q)
  );
`else
  always_ff @(posedge clk_i) begin
    if (cs) rd_q <= mem[sel_addr];
  end
`endif

  assign par_err = (ParityEn != 0) && par_odd(MaxPw'(rd_q));

  always_comb begin
    rsp1.valid = s1_q.valid;
    rsp1.ch    = s1_q.ch;
    rsp1.err   = s1_q.err_pre | par_err;
    rsp1.data  = rsp1.err ? '0 : rd_q[Width-1:0];
  end

  generate
    if (OutReg != 0) begin : g_oreg
      rom_rsp_t s2_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) s2_q <= '0;
        else       s2_q <= rsp1;
      end
      assign rsp_out = s2_q;
    end else begin : g_noreg
      assign rsp_out = rsp1;
    end
  endgenerate

  // Only the addressed channel sees a response; all others read as zero.
  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    logic hit;
    assign hit                       = rsp_out.valid && (rsp_out.ch == ChW'(c));
    assign rvalid_o[c]               = hit;
    assign err_o[c]                  = hit & rsp_out.err;
    assign rdata_o[c*Width +: Width] = hit ? rsp_out.data : '0;
  end
endmodule
